// File: rtl/fe_capture_usb_gen.sv
// USB front-end capture: aligns UTMI/ULPI data and status, packs DATA/STAT/TIME
// words for the sniff FIFO, and reports lost writes with a DROP entry on recovery.
module fe_capture_usb_gen #(
  parameter int pDATA_WIDTH            = 8,
  parameter int pSTATUS_BITS           = 5,
  parameter int pDELAY                 = 3,
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3,
  parameter int pDROP_CNT_WIDTH        = 16,
  parameter int pFIFO_WIDTH            = 2 + pTIMESTAMP_SHORT_WIDTH + pDATA_WIDTH + pSTATUS_BITS
) (
  input  logic                             fe_clk,
  input  logic                             reset_n,
  input  logic [pDATA_WIDTH-1:0]           fe_data,
  input  logic                             fe_rxvalid,
  input  logic [pSTATUS_BITS-1:0]          fe_status,
  input  logic [pSTATUS_BITS-1:0]          I_status_mask,
  input  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_fifo_time,
  input  logic [1:0]                       I_fifo_command,
  input  logic                             I_fifo_wr,
  input  logic                             I_fifo_write_allowed,
  input  logic                             I_clear_overflow,
  output logic                             O_event,
  output logic [1:0]                       O_data_cmd,
  output logic [pSTATUS_BITS-1:0]          O_fifo_fe_status,
  output logic [pFIFO_WIDTH-1:0]           O_fifo_data,
  output logic                             O_fifo_wr,
  output logic                             O_overflow,
  output logic                             O_drop_state
);

  localparam logic [1:0] CMD_DATA = 2'b00;
  localparam logic [1:0] CMD_STAT = 2'b01;
  localparam logic [1:0] CMD_TIME = 2'b10;
  localparam logic [1:0] CMD_DROP = 2'b11;
  localparam int         TS       = pTIMESTAMP_SHORT_WIDTH;
  localparam int         DW       = pDATA_WIDTH;
  localparam logic [pDROP_CNT_WIDTH-1:0] CNT_ONE = pDROP_CNT_WIDTH'(1);

  if (pDELAY < 1) begin : g_bad_delay
    $error("fe_capture_usb_gen: pDELAY must be at least 1");
  end
  if (pFIFO_WIDTH < 2 + pTIMESTAMP_FULL_WIDTH) begin : g_bad_time_w
    $error("fe_capture_usb_gen: pFIFO_WIDTH too small for TIME entries");
  end
  if (pFIFO_WIDTH < 2 + pDROP_CNT_WIDTH) begin : g_bad_drop_w
    $error("fe_capture_usb_gen: pFIFO_WIDTH too small for DROP entries");
  end
  if (pFIFO_WIDTH < 2 + TS + DW + pSTATUS_BITS) begin : g_bad_data_w
    $error("fe_capture_usb_gen: pFIFO_WIDTH too small for DATA/STAT entries");
  end
  if (TS > pTIMESTAMP_FULL_WIDTH) begin : g_bad_short_w
    $error("fe_capture_usb_gen: short timestamp wider than full timestamp");
  end

  typedef enum logic {ST_NORMAL = 1'b0, ST_DROPPING = 1'b1} state_t;

  function automatic logic [pDROP_CNT_WIDTH-1:0] sat_inc(input logic [pDROP_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [DW-1:0]           r_data_pipe   [pDELAY];
  logic [pSTATUS_BITS-1:0] r_status_pipe [pDELAY];
  logic [pDELAY-1:0]       r_rxvalid_pipe;

  logic [DW-1:0]           w_data_d;
  logic [pSTATUS_BITS-1:0] w_status_d;
  logic                    w_rxvalid_d;

  state_t                     r_state, w_state_nxt;
  logic [pDROP_CNT_WIDTH-1:0] r_drop_cnt;
  logic [pDROP_CNT_WIDTH-1:0] w_drop_report;
  logic                       w_pass_wr, w_drop_start, w_drop_count, w_drop_emit, w_lost;
  logic [1:0]                 w_cmd;
  logic [pFIFO_WIDTH-1:0]     w_word;
  logic [pFIFO_WIDTH-1:0]     r_fifo_data;
  logic                       r_fifo_wr, r_overflow;

  // Alignment pipelines; data stage 0 holds the last valid byte.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < pDELAY; i++) begin
        r_data_pipe[i]   <= '0;
        r_status_pipe[i] <= '0;
      end
      r_rxvalid_pipe <= '0;
    end else begin
      if (fe_rxvalid) r_data_pipe[0] <= fe_data;
      r_status_pipe[0]  <= fe_status;
      r_rxvalid_pipe[0] <= fe_rxvalid;
      for (int i = 1; i < pDELAY; i++) begin
        r_data_pipe[i]    <= r_data_pipe[i-1];
        r_status_pipe[i]  <= r_status_pipe[i-1];
        r_rxvalid_pipe[i] <= r_rxvalid_pipe[i-1];
      end
    end
  end

  assign w_data_d    = r_data_pipe[pDELAY-1];
  assign w_status_d  = r_status_pipe[pDELAY-1];
  assign w_rxvalid_d = r_rxvalid_pipe[pDELAY-1];

  assign O_event          = fe_rxvalid | (|((fe_status ^ r_status_pipe[0]) & I_status_mask));
  assign O_data_cmd       = w_rxvalid_d ? CMD_DATA : CMD_STAT;
  assign O_fifo_fe_status = w_status_d;

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_NORMAL;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL:   if (I_fifo_wr && !I_fifo_write_allowed) w_state_nxt = ST_DROPPING;
      ST_DROPPING: if (I_fifo_write_allowed) w_state_nxt = ST_NORMAL;
      default:     w_state_nxt = ST_NORMAL;
    endcase
  end

  always_comb begin
    w_pass_wr    = 1'b0;
    w_drop_start = 1'b0;
    w_drop_count = 1'b0;
    w_drop_emit  = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        w_pass_wr    = I_fifo_wr & I_fifo_write_allowed;
        w_drop_start = I_fifo_wr & ~I_fifo_write_allowed;
      end
      ST_DROPPING: begin
        w_drop_emit  = I_fifo_write_allowed;
        w_drop_count = I_fifo_wr & ~I_fifo_write_allowed;
      end
      default: ;
    endcase
  end

  // A write arriving on the recovery cycle is lost but still counted in the report.
  assign w_drop_report = I_fifo_wr ? sat_inc(r_drop_cnt) : r_drop_cnt;
  assign w_lost        = w_drop_start | w_drop_count | (w_drop_emit & I_fifo_wr);

  always_comb begin
    w_cmd       = w_drop_emit ? CMD_DROP : I_fifo_command;
    w_word      = '0;
    w_word[1:0] = w_cmd;
    case (w_cmd)
      CMD_DATA: begin
        w_word[2 +: TS]                     = I_fifo_time[TS-1:0];
        w_word[2 + TS +: DW]                = w_data_d;
        w_word[2 + TS + DW +: pSTATUS_BITS] = w_status_d;
      end
      CMD_STAT: begin
        w_word[2 +: TS]                     = I_fifo_time[TS-1:0];
        w_word[2 + TS + DW +: pSTATUS_BITS] = w_status_d;
      end
      CMD_TIME: w_word[2 +: pTIMESTAMP_FULL_WIDTH] = I_fifo_time;
      default:  w_word[2 +: pDROP_CNT_WIDTH] = w_drop_emit ? w_drop_report : '0;
    endcase
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop_start) begin
      r_drop_cnt <= CNT_ONE;
    end else if (w_drop_count) begin
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end else if (w_drop_emit) begin
      r_drop_cnt <= '0;
    end
  end

  // Write port: one cycle latency from request to strobe.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo_wr   <= 1'b0;
      r_fifo_data <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_fifo_wr <= w_pass_wr | w_drop_emit;
      if (w_pass_wr || w_drop_emit) r_fifo_data <= w_word;
      if (w_lost)                r_overflow <= 1'b1;
      else if (I_clear_overflow) r_overflow <= 1'b0;
    end
  end

  assign O_fifo_data  = r_fifo_data;
  assign O_fifo_wr    = r_fifo_wr;
  assign O_overflow   = r_overflow;
  assign O_drop_state = (r_state == ST_DROPPING);

endmodule

// File: tb/tb_fe_capture_usb_gen.sv
// Bench for fe_capture_usb_gen: two instances (16-bit and 4-bit drop counters) driven
// identically and compared every cycle against a cycle-indexed behavioural model.
module tb_fe_capture_usb_gen;
  localparam int DW = 8, SB = 5, DLY = 3, TF = 16, TS = 3, CW0 = 16, CW1 = 4;
  localparam int FW = 2 + TS + DW + SB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] fe_data = '0;
  logic          fe_rxvalid = 1'b0;
  logic [SB-1:0] fe_status = '0, mask = '0;
  logic [TF-1:0] ftime = '0;
  logic [1:0]    fcmd = '0;
  logic          fwr = 1'b0, allowed = 1'b0, clr = 1'b0;

  logic          ev0, ev1, wr0, wr1, ovf0, ovf1, ds0, ds1;
  logic [1:0]    dcmd0, dcmd1;
  logic [SB-1:0] st0, st1;
  logic [FW-1:0] fd0, fd1;

  always #5 clk = ~clk;

  fe_capture_usb_gen #(.pDROP_CNT_WIDTH(CW0)) u_dut0 (
    .fe_clk(clk), .reset_n(rst_n), .fe_data(fe_data), .fe_rxvalid(fe_rxvalid),
    .fe_status(fe_status), .I_status_mask(mask), .I_fifo_time(ftime),
    .I_fifo_command(fcmd), .I_fifo_wr(fwr), .I_fifo_write_allowed(allowed),
    .I_clear_overflow(clr), .O_event(ev0), .O_data_cmd(dcmd0),
    .O_fifo_fe_status(st0), .O_fifo_data(fd0), .O_fifo_wr(wr0),
    .O_overflow(ovf0), .O_drop_state(ds0));

  fe_capture_usb_gen #(.pDROP_CNT_WIDTH(CW1)) u_dut1 (
    .fe_clk(clk), .reset_n(rst_n), .fe_data(fe_data), .fe_rxvalid(fe_rxvalid),
    .fe_status(fe_status), .I_status_mask(mask), .I_fifo_time(ftime),
    .I_fifo_command(fcmd), .I_fifo_wr(fwr), .I_fifo_write_allowed(allowed),
    .I_clear_overflow(clr), .O_event(ev1), .O_data_cmd(dcmd1),
    .O_fifo_fe_status(st1), .O_fifo_data(fd1), .O_fifo_wr(wr1),
    .O_overflow(ovf1), .O_drop_state(ds1));

  int n_chk = 0, n_err = 0;

  // Model: input history per clock edge since reset, plus per-instance drop bookkeeping.
  logic [DW-1:0] h_d  [8192];
  logic [SB-1:0] h_st [8192];
  bit            h_rv [8192];
  logic [DW-1:0] held;
  int            cyc;
  bit            m_drop [2];
  int            m_cnt  [2];
  bit            m_ovf  [2];
  bit            m_wr   [2];
  logic [63:0]   m_word [2];
  int            m_max  [2] = '{(1 << CW0) - 1, (1 << CW1) - 1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    held = '0;
    cyc  = 0;
    for (int i = 0; i < 2; i++) begin
      m_drop[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_wr[i] = 0; m_word[i] = '0;
    end
  endtask

  // Entered and left at a falling edge: drive, check combinational outputs,
  // advance the model across the rising edge, then check registered outputs.
  task automatic step(input logic [DW-1:0] d, input logic rv, input logic [SB-1:0] st,
                      input logic [SB-1:0] mk, input logic [TF-1:0] t, input logic [1:0] c,
                      input logic w, input logic al, input logic cl);
    logic [DW-1:0] td;
    logic [SB-1:0] tst, sr1;
    bit            trv, e_ev, was_drop;
    logic [63:0]   nw;
    fe_data = d; fe_rxvalid = rv; fe_status = st; mask = mk;
    ftime = t; fcmd = c; fwr = w; allowed = al; clr = cl;
    #1;
    td  = (cyc >= DLY) ? h_d[cyc-DLY]  : '0;
    tst = (cyc >= DLY) ? h_st[cyc-DLY] : '0;
    trv = (cyc >= DLY) ? h_rv[cyc-DLY] : 1'b0;
    sr1 = (cyc >= 1)   ? h_st[cyc-1]   : '0;
    e_ev = rv | (|((st ^ sr1) & mk));
    chk("event0", 64'(ev0), 64'(e_ev));
    chk("event1", 64'(ev1), 64'(e_ev));
    chk("data_cmd", 64'(dcmd0), trv ? 64'd0 : 64'd1);
    chk("fe_status", 64'(st0), 64'(tst));

    case (c)
      2'b00:   nw = 64'(c) | ((64'(t) % (64'd1 << TS)) << 2) | (64'(td) << (2 + TS)) | (64'(tst) << (2 + TS + DW));
      2'b01:   nw = 64'(c) | ((64'(t) % (64'd1 << TS)) << 2) | (64'(tst) << (2 + TS + DW));
      2'b10:   nw = 64'(c) | (64'(t) << 2);
      default: nw = 64'(c);
    endcase

    for (int i = 0; i < 2; i++) begin
      was_drop = m_drop[i];
      m_wr[i]  = 0;
      if (!was_drop) begin
        if (w && al) begin
          m_wr[i] = 1; m_word[i] = nw;
        end else if (w) begin
          m_drop[i] = 1; m_cnt[i] = 1;
        end
      end else begin
        if (w) m_cnt[i] = (m_cnt[i] + 1 > m_max[i]) ? m_max[i] : m_cnt[i] + 1;
        if (al) begin
          m_wr[i] = 1; m_word[i] = (64'(m_cnt[i]) << 2) | 64'd3;
          m_drop[i] = 0; m_cnt[i] = 0;
        end
      end
      if (w && (was_drop || !al)) m_ovf[i] = 1;
      else if (cl)                m_ovf[i] = 0;
    end
    h_st[cyc] = st;
    h_rv[cyc] = rv;
    if (rv) held = d;
    h_d[cyc] = held;
    cyc++;

    @(negedge clk);
    chk("fifo_wr0", 64'(wr0), 64'(m_wr[0]));
    chk("fifo_data0", 64'(fd0), m_word[0]);
    chk("overflow0", 64'(ovf0), 64'(m_ovf[0]));
    chk("drop_state0", 64'(ds0), 64'(m_drop[0]));
    chk("fifo_wr1", 64'(wr1), 64'(m_wr[1]));
    chk("fifo_data1", 64'(fd1), m_word[1]);
    chk("overflow1", 64'(ovf1), 64'(m_ovf[1]));
    chk("drop_state1", 64'(ds1), 64'(m_drop[1]));
  endtask

  initial begin
    bit            blocked;
    logic [SB-1:0] rst_st, rmk;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_fifo_wr", 64'(wr0), 64'd0);
    chk("rst_fifo_data", 64'(fd0), 64'd0);
    chk("rst_overflow", 64'(ovf0), 64'd0);
    chk("rst_drop_state", 64'(ds0), 64'd0);
    chk("rst_data_cmd", 64'(dcmd0), 64'd1);
    rst_n = 1'b1;

    // Aligned DATA entry
    step(8'hA5, 1'b1, 5'b00001, 5'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b0, 5'b00001, 5'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(8'h3C, 1'b0, 5'b00001, 5'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b0, 5'b00001, 5'b0, 16'h0005, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("a5_wr", 64'(wr0), 64'd1);
    chk("a5_word", 64'(fd0), 64'({5'b00001, 8'hA5, 3'd5, 2'b00}));

    // Status mask: bit 2 toggle is masked, bit 0 toggle raises the event
    step(8'h00, 1'b0, 5'b00101, 5'b00001, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b0, 5'b00100, 5'b00001, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);

    // TIME entry
    step(8'h00, 1'b0, 5'b00100, 5'b00001, 16'h1234, 2'b10, 1'b1, 1'b1, 1'b0);
    chk("time_field", 64'(fd0[17:2]), 64'h1234);
    chk("time_cmd", 64'(fd0[1:0]), 64'd2);

    // Three drops then recovery
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 5'b00100, 5'b0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b0, 5'b00100, 5'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("drop3_word", 64'(fd0), 64'({16'd3, 2'b11}));
    chk("drop3_ovf", 64'(ovf0), 64'd1);
    step(8'h00, 1'b0, 5'b00100, 5'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("drop3_single", 64'(wr0), 64'd0);
    step(8'h00, 1'b0, 5'b00100, 5'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("ovf_cleared", 64'(ovf0), 64'd0);

    // 20 drops plus one on the recovery cycle: 4-bit counter saturates
    for (int i = 0; i < 20; i++) step(8'h00, 1'b0, 5'b00100, 5'b0, 16'h0, 2'b01, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b0, 5'b00100, 5'b0, 16'h0, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("sat_count4", 64'(fd1[5:2]), 64'd15);
    chk("sat_cmd4", 64'(fd1[1:0]), 64'd3);
    chk("count16", 64'(fd0[17:2]), 64'd21);

    // Asynchronous reset while dropping with count 5
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 5'b00100, 5'b0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_drop", 64'(ds0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fifo_wr", 64'(wr0), 64'd0);
    chk("arst_fifo_data", 64'(fd0), 64'd0);
    chk("arst_overflow", 64'(ovf0), 64'd0);
    chk("arst_drop_state", 64'(ds0), 64'd0);
    chk("arst_fe_status", 64'(st0), 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h00, 1'b0, 5'b00000, 5'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("post_rst_no_drop", 64'(wr0), 64'd0);

    // Randomised traffic with blocked-FIFO bursts
    blocked = 0;
    rst_st  = '0;
    rmk     = '1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0) blocked = !blocked;
      if ($urandom_range(0, 3) == 0) rst_st[$urandom_range(0, SB - 1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) rmk = SB'($urandom);
      step(DW'($urandom), ($urandom_range(0, 2) == 0), rst_st, rmk, TF'($urandom),
           2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
           blocked ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
